// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART serial core: frame timing constants,
//   counter widths and the state encoding used by both the TX and RX engines.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int TICKS_PER_BIT = 4;  // sio_ce_x4 ticks per serial bit
  localparam int DATA_BITS     = 8;  // 8N1 payload width
  localparam int TICK_W        = $clog2(TICKS_PER_BIT);
  localparam int BIT_W         = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_t;

endpackage

// File: rtl/uart_fifo.sv
// -----------------------------------------------------------------------------
// uart_fifo
//   Synchronous FIFO with count-based full/empty and first-word fall-through
//   read: rdata always shows the head entry without a read request.
//   A pop on a non-empty FIFO and a push in the same cycle both take effect;
//   a push into a full FIFO is accepted only when a pop frees a slot that
//   same cycle.
//
// Ports
//   clk, resetn   clock, synchronous active-low reset
//   push, wdata   write request and data
//   pop           remove head entry (ignored when empty)
//   rdata         head entry (combinational)
//   full, empty   occupancy flags
// -----------------------------------------------------------------------------
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: storage is cleared on reset so the FWFT head reads 0 afterwards;
      // this costs a reset mux per bit and is only worth it because dout is
      // visible while empty.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_serial_core.sv
// -----------------------------------------------------------------------------
// uart_serial_core
//   8N1 UART with TX and RX byte FIFOs. Bit timing is derived from an external
//   one-clock tick at 4x the bit rate; both serial engines only advance on
//   that tick, while FIFO pushes/pops run every clock.
//
// Ports
//   clk, resetn   clock, synchronous active-low reset
//   sio_ce_x4     one-clk tick at 4x bit rate
//   din, we       TX byte and push strobe (ignored while full)
//   full          TX FIFO full
//   re, dout      RX pop strobe and RX head (fall-through)
//   empty         RX FIFO empty
//   err_clr       clears overrun / frame_err (a same-cycle set wins)
//   overrun       sticky: received byte dropped because RX FIFO was full
//   frame_err     sticky: stop bit sampled low
//   rxd           asynchronous serial input
//   txd           serial output, idle high
// -----------------------------------------------------------------------------
module uart_serial_core
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sio_ce_x4,
  input  logic [7:0] din,
  input  logic       we,
  input  logic       re,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  input  logic       err_clr,
  output logic       overrun,
  output logic       frame_err,
  input  logic       rxd,
  output logic       txd
);

  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(TICKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  // ---------------------------------------------------------------------------
  // TX path
  // ---------------------------------------------------------------------------
  uart_state_t          tx_state;
  logic [TICK_W-1:0]    tx_tick;
  logic [BIT_W-1:0]     tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_empty;
  logic                 tx_pop;

  // A new frame is launched from IDLE or straight out of the last STOP tick,
  // so back-to-back bytes leave no idle bit between frames.
  assign tx_pop = sio_ce_x4 && !tx_empty &&
                  ((tx_state == ST_IDLE) ||
                   (tx_state == ST_STOP && tx_tick == LAST_TICK));

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_tx_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (we && !full),
    .wdata  (din),
    .pop    (tx_pop),
    .rdata  (tx_head),
    .full   (full),
    .empty  (tx_empty)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_state <= ST_IDLE;
      tx_tick  <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      txd      <= 1'b1;
    end else if (sio_ce_x4) begin
      if (tx_pop) begin
        tx_state <= ST_START;
        tx_sh    <= tx_head;
        tx_tick  <= '0;
        tx_bit   <= '0;
        txd      <= 1'b0;
      end else begin
        case (tx_state)
          ST_IDLE: begin
            txd <= 1'b1;
          end
          ST_START: begin
            if (tx_tick == LAST_TICK) begin
              tx_state <= ST_DATA;
              tx_tick  <= '0;
              txd      <= tx_sh[0];
            end else begin
              tx_tick <= tx_tick + 1'b1;
            end
          end
          ST_DATA: begin
            if (tx_tick == LAST_TICK) begin
              tx_tick <= '0;
              if (tx_bit == LAST_BIT) begin
                tx_state <= ST_STOP;
                txd      <= 1'b1;
              end else begin
                tx_bit <= tx_bit + 1'b1;
                tx_sh  <= {1'b0, tx_sh[DATA_BITS-1:1]};
                txd    <= tx_sh[1];
              end
            end else begin
              tx_tick <= tx_tick + 1'b1;
            end
          end
          ST_STOP: begin
            if (tx_tick == LAST_TICK) begin
              tx_state <= ST_IDLE;
              tx_tick  <= '0;
            end else begin
              tx_tick <= tx_tick + 1'b1;
            end
          end
          default: begin
            tx_state <= ST_IDLE;
            txd      <= 1'b1;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------------------
  logic                 rxd_meta;
  logic                 rxd_sync;
  uart_state_t          rx_state;
  logic [TICK_W-1:0]    rx_tick;
  logic [BIT_W-1:0]     rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_wait_high;  // stop bit was low; hold until line idles
  logic                 rx_full;
  logic                 stop_sample;
  logic                 rx_push;
  logic                 overrun_set;
  logic                 frame_set;

  // Two-flop synchronizer; resets to the idle-line level so a reset does not
  // look like a start bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
    end
  end

  assign stop_sample = sio_ce_x4 && (rx_state == ST_STOP) && !rx_wait_high &&
                       (rx_tick == LAST_TICK);
  assign rx_push     = stop_sample && rxd_sync;
  assign frame_set   = stop_sample && !rxd_sync;
  // A full FIFO still takes the byte when re frees a slot the same cycle;
  // re with full=1 is always an effective pop since full implies non-empty.
  assign overrun_set = rx_push && rx_full && !re;

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_rx_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (rx_push),
    .wdata  (rx_sh),
    .pop    (re),
    .rdata  (dout),
    .full   (rx_full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_state     <= ST_IDLE;
      rx_tick      <= '0;
      rx_bit       <= '0;
      rx_sh        <= '0;
      rx_wait_high <= 1'b0;
    end else if (sio_ce_x4) begin
      case (rx_state)
        ST_IDLE: begin
          if (!rxd_sync) begin
            rx_state <= ST_START;
            rx_tick  <= '0;
          end
        end
        ST_START: begin
          // Re-check at mid-bit; a line back high by then was a glitch.
          if (rx_tick == MID_TICK) begin
            rx_tick  <= '0;
            rx_bit   <= '0;
            rx_state <= rxd_sync ? ST_IDLE : ST_DATA;
          end else begin
            rx_tick <= rx_tick + 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_tick == LAST_TICK) begin
            rx_tick <= '0;
            rx_sh   <= {rxd_sync, rx_sh[DATA_BITS-1:1]};
            if (rx_bit == LAST_BIT) begin
              rx_state <= ST_STOP;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_tick <= rx_tick + 1'b1;
          end
        end
        ST_STOP: begin
          if (rx_wait_high) begin
            if (rxd_sync) begin
              rx_state     <= ST_IDLE;
              rx_wait_high <= 1'b0;
            end
          end else if (rx_tick == LAST_TICK) begin
            rx_tick <= '0;
            if (rxd_sync) begin
              rx_state <= ST_IDLE;
            end else begin
              rx_wait_high <= 1'b1;
            end
          end else begin
            rx_tick <= rx_tick + 1'b1;
          end
        end
        default: begin
          rx_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky error flags: a set event in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= overrun_set || (overrun && !err_clr);
      frame_err <= frame_set || (frame_err && !err_clr);
    end
  end

endmodule

// File: doc/uart_serial_core.md
UART_SERIAL_CORE -- requirements
Module: uart_serial_core

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning TX and RX FIFO depth in bytes (power of two, ≥2).
REQ-002 SHALL have ports: clk  input  1  system clock.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 sio_ce_x4  input  1  one-clk-wide tick at 4x bit rate.
REQ-005 din  input  8  TX byte.
REQ-006 we  input  1  push din into TX FIFO.
REQ-007 re  input  1  pop RX FIFO head.
REQ-008 dout  output  8  RX FIFO head (first-word fall-through).
REQ-009 full  output  1  TX FIFO full.
REQ-010 empty  output  1  RX FIFO empty.
REQ-011 err_clr  input  1  clears sticky error flags.
REQ-012 overrun  output  1  sticky: RX byte lost because RX FIFO full.
REQ-013 frame_err  output  1  sticky: stop bit sampled 0.
REQ-014 rxd  input  1  serial in, asynchronous.
REQ-015 txd  output  1  serial out, idle high.

Function
REQ-016 Frame format SHALL be 8N1, LSB first; one bit period = 4 sio_ce_x4 ticks.
REQ-017 we with full=0 SHALL push din the same edge; we with full=1 SHALL be ignored, no state change.
REQ-018 full SHALL be 1 exactly when TX FIFO count == FIFO_DEPTH; empty SHALL be 1 exactly when RX FIFO count == 0.
REQ-019 dout SHALL show the RX head combinationally; re with empty=0 pops at the edge; re with empty=1 is ignored.
REQ-020 TX FSM states IDLE, START, DATA, STOP; IDLE->START on a tick with TX FIFO non-empty, popping the byte that edge.
REQ-021 TX SHALL drive txd=0 for 4 ticks (START), then 8 data bits of 4 ticks each (DATA), then txd=1 for 4 ticks (STOP), then IDLE.
REQ-022 TX SHALL start the next queued byte on the first tick after STOP completes; no extra idle bit between frames.
REQ-023 rxd SHALL pass a 2-flop synchronizer (reset value 1) before any use.
REQ-024 RX FSM states IDLE, START, DATA, STOP; IDLE->START on a tick sampling synced rxd=0.
REQ-025 START SHALL re-sample 2 ticks later (mid-bit); 0 -> DATA, 1 -> IDLE (glitch, no flag).
REQ-026 DATA SHALL sample every 4 ticks from mid-start, shifting in 8 bits LSB first, then STOP samples 4 ticks later.
REQ-027 Stop bit 1 with RX FIFO not full SHALL push the byte; not full is evaluated after any same-cycle re pop.
REQ-028 Stop bit 1 with RX FIFO full (and no same-cycle re) SHALL discard the byte and set overrun.
REQ-029 Stop bit 0 SHALL discard the byte, set frame_err, and return to IDLE only after synced rxd=1.
REQ-030 Simultaneous push and pop on either FIFO SHALL both take effect; count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-031 err_clr SHALL clear both flags; a set event in the same cycle wins.
REQ-032 Without sio_ce_x4 ticks, both FSMs SHALL hold state; FIFO push/pop still operate.

Reset
REQ-033 On resetn=0 at a clk edge: both FSMs IDLE, bit/tick counters 0, FIFO pointers and counts 0, storage 0.
REQ-034 Reset outputs: txd=1, full=0, empty=1, dout=8'h00, overrun=0, frame_err=0.
REQ-035 Reset mid-frame SHALL abort the frame; txd=1 the next cycle; the partial RX byte is discarded.

Structure
REQ-036 Package uart_pkg SHALL hold the TX/RX state enum, TICKS_PER_BIT=4, DATA_BITS=8.
REQ-037 A sub-module uart_fifo (synchronous, count-based full/empty, FWFT read) SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-038 Tick every 8 clks, push 8'hA5 -> txd: 0, 1,0,1,0,0,1,0,1, 1, 4 ticks per bit; full never asserted.
REQ-039 Push 5 bytes 8'h01..8'h05 back-to-back with FIFO_DEPTH=4 and TX busy -> full=1 after the 4th accepted byte, the 5th is ignored, 4 frames are sent in order with no gap.
REQ-040 Drive rxd with 8'h3C frame in loopback (txd->rxd) -> empty falls, dout=8'h3C, re pops, empty=1.
REQ-041 Send 5 frames without re (depth 4) -> dout=first byte, overrun=1; err_clr -> overrun=0.
REQ-042 rxd low pulse of 1 tick -> RX returns to IDLE, empty=1, no flags; frame with stop=0 -> frame_err=1, no push.
REQ-043 Assert resetn=0 mid TX DATA bit 3 -> txd=1 next cycle, full=0, empty=1, all flags 0.
